// File: rtl/sdram_synth_model.sv
// Cycle-accurate SDR SDRAM model with split DQ buses.
// Runtime CL/BL via MRS, open-row tracking, DQM and sticky error flags.
module sdram_synth_model #(
  parameter int W_BANKSEL = 2,
  parameter int W_ADDR    = 13,
  parameter int W_DATA    = 16,
  parameter int W_ROW     = 13,
  parameter int W_COL     = 10,
  parameter int W_MEM     = 14
) (
  input  logic                  clk_sys,
  input  logic                  rst_n_por,
  input  logic [W_BANKSEL-1:0]  sdram_ba,
  input  logic [W_ADDR-1:0]     sdram_a,
  input  logic [W_DATA/8-1:0]   sdram_dqm,
  input  logic [W_DATA-1:0]     sdram_dq_o,
  output logic [W_DATA-1:0]     sdram_dq_i,
  input  logic                  sdram_clke,
  input  logic                  sdram_cs_n,
  input  logic                  sdram_ras_n,
  input  logic                  sdram_cas_n,
  input  logic                  sdram_we_n,
  input  logic                  err_clear,
  output logic [3:0]            err_flags
);

  localparam int W_BE   = W_DATA / 8;
  localparam int N_BANK = 1 << W_BANKSEL;
  localparam int W_FULL = W_BANKSEL + W_ROW + W_COL;
  localparam int DEPTH  = 1 << W_MEM;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_BST = 3'b110;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [W_DATA-1:0]    mem [DEPTH];

  logic [1:0]           bl_q, bl_d;
  logic                 cl3_q, cl3_d;
  logic [N_BANK-1:0]    open_q, open_d;
  logic [W_ROW-1:0]     row_q [N_BANK];
  logic [W_ROW-1:0]     row_d [N_BANK];
  logic [1:0]           st_q, st_d;
  logic [W_BANKSEL-1:0] bba_q, bba_d;
  logic [W_ROW-1:0]     brow_q, brow_d;
  logic [W_COL-1:0]     bcol_q, bcol_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 p1_v_q, p1_v_d;
  logic                 p2_v_q, p2_v_d;
  logic [W_MEM-1:0]     p1_a_q, p1_a_d;
  logic [W_MEM-1:0]     p2_a_q, p2_a_d;
  logic [W_BE-1:0]      dqm_q, dqm_d;
  logic [W_DATA-1:0]    dq_i_q, dq_i_d;
  logic [3:0]           err_q, err_d;

  logic [2:0]           cmd;
  logic                 take;
  logic [3:0]           bl_len;
  logic [3:0]           err_set;
  logic                 iss_v;
  logic [W_MEM-1:0]     iss_a;
  logic                 wr_en;
  logic [W_MEM-1:0]     wr_a;
  logic [W_DATA-1:0]    wr_data;
  logic [W_BE-1:0]      wr_be;
  logic [W_DATA-1:0]    rd_word;
  logic                 is_act, is_rd, is_wr;
  logic                 is_pre, is_ref, is_mrs, is_bst;
  logic                 mode_ok;

  function automatic logic [W_COL-1:0] burst_col(
    input logic [W_COL-1:0] c,
    input logic [3:0]       k,
    input logic [1:0]       bl
  );
    logic [W_COL-1:0] m;
    m = W_COL'((4'd1 << bl) - 4'd1);
    return (c & ~m) | ((c + W_COL'(k)) & m);
  endfunction

  function automatic logic [W_MEM-1:0] mem_idx(
    input logic [W_BANKSEL-1:0] ba,
    input logic [W_ROW-1:0]     row,
    input logic [W_COL-1:0]     col
  );
    logic [W_FULL-1:0] f;
    f = {ba, row, col};
    return f[W_MEM-1:0];
  endfunction

  // read port: word leaving the CL pipeline, with DQM lanes zeroed
  always_comb begin
    rd_word = mem[cl3_q ? p2_a_q : p1_a_q];
    for (int b = 0; b < W_BE; b++) begin
      if (dqm_q[b]) rd_word[8*b +: 8] = 8'h00;
    end
  end

  // command decode, burst engine, read pipeline and error flags
  always_comb begin
    cmd     = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    take    = sdram_clke & ~sdram_cs_n;
    bl_len  = 4'd1 << bl_q;
    is_act  = take && cmd == CMD_ACT;
    is_rd   = take && cmd == CMD_RD;
    is_wr   = take && cmd == CMD_WR;
    is_pre  = take && cmd == CMD_PRE;
    is_ref  = take && cmd == CMD_REF;
    is_mrs  = take && cmd == CMD_MRS;
    is_bst  = take && cmd == CMD_BST;
    mode_ok = !sdram_a[3] && !sdram_a[2] &&
              sdram_a[6:5] == 2'b01;
    bl_d    = bl_q;
    cl3_d   = cl3_q;
    open_d  = open_q;
    row_d   = row_q;
    st_d    = st_q;
    bba_d   = bba_q;
    brow_d  = brow_q;
    bcol_d  = bcol_q;
    bcnt_d  = bcnt_q;
    p1_v_d  = p1_v_q;
    p1_a_d  = p1_a_q;
    p2_v_d  = p2_v_q;
    p2_a_d  = p2_a_q;
    dqm_d   = dqm_q;
    dq_i_d  = dq_i_q;
    err_set = 4'b0000;
    iss_v   = 1'b0;
    iss_a   = '0;
    wr_en   = 1'b0;
    wr_a    = '0;
    wr_data = sdram_dq_o;
    wr_be   = ~sdram_dqm;
    if (sdram_clke) begin
      dqm_d  = sdram_dqm;
      p2_v_d = p1_v_q;
      p2_a_d = p1_a_q;
      dq_i_d = (cl3_q ? p2_v_q : p1_v_q) ? rd_word : '0;
      if (st_q != ST_IDLE) begin
        if (st_q == ST_RD) begin
          iss_v = 1'b1;
          iss_a = mem_idx(bba_q, brow_q,
                          burst_col(bcol_q, bcnt_q, bl_q));
        end else begin
          wr_en = 1'b1;
          wr_a  = mem_idx(bba_q, brow_q,
                          burst_col(bcol_q, bcnt_q, bl_q));
        end
        bcnt_d = bcnt_q + 4'd1;
        if (bcnt_q + 4'd1 == bl_len) st_d = ST_IDLE;
      end
      unique case (1'b1)
        is_act: begin
          if (open_q[sdram_ba]) err_set[1] = 1'b1;
          open_d[sdram_ba] = 1'b1;
          row_d[sdram_ba]  = sdram_a[W_ROW-1:0];
        end
        is_rd, is_wr: begin
          if (!open_q[sdram_ba]) begin
            err_set[0] = 1'b1;
          end else begin
            iss_v  = 1'b0;
            wr_en  = 1'b0;
            bba_d  = sdram_ba;
            brow_d = row_q[sdram_ba];
            bcol_d = sdram_a[W_COL-1:0];
            bcnt_d = 4'd1;
            st_d   = ST_IDLE;
            if (is_rd) begin
              iss_v = 1'b1;
              iss_a = mem_idx(sdram_ba, row_q[sdram_ba],
                              sdram_a[W_COL-1:0]);
              if (bl_q != 2'd0) st_d = ST_RD;
            end else begin
              wr_en  = 1'b1;
              wr_a   = mem_idx(sdram_ba, row_q[sdram_ba],
                               sdram_a[W_COL-1:0]);
              p2_v_d = 1'b0;
              dq_i_d = '0;
              if (bl_q != 2'd0) st_d = ST_WR;
            end
          end
        end
        is_pre: begin
          if (st_q != ST_IDLE &&
              (sdram_a[10] || sdram_ba == bba_q)) begin
            st_d  = ST_IDLE;
            iss_v = 1'b0;
            wr_en = 1'b0;
          end
          if (sdram_a[10]) open_d = '0;
          else open_d[sdram_ba] = 1'b0;
        end
        is_bst: begin
          st_d  = ST_IDLE;
          iss_v = 1'b0;
          wr_en = 1'b0;
        end
        is_ref: begin
          if (|open_q) err_set[2] = 1'b1;
        end
        is_mrs: begin
          if (|open_q) begin
            err_set[2] = 1'b1;
          end else if (!mode_ok) begin
            err_set[3] = 1'b1;
          end else begin
            bl_d  = sdram_a[1:0];
            cl3_d = sdram_a[4];
          end
        end
        default: ;
      endcase
      p1_v_d = iss_v;
      p1_a_d = iss_a;
    end
    err_d = (err_clear ? 4'b0000 : err_q) | err_set;
  end

  // state registers
  always_ff @(posedge clk_sys or negedge rst_n_por) begin
    if (!rst_n_por) begin
      bl_q   <= 2'd3;
      cl3_q  <= 1'b0;
      open_q <= '0;
      for (int i = 0; i < N_BANK; i++) row_q[i] <= '0;
      st_q   <= ST_IDLE;
      bba_q  <= '0;
      brow_q <= '0;
      bcol_q <= '0;
      bcnt_q <= '0;
      p1_v_q <= 1'b0;
      p1_a_q <= '0;
      p2_v_q <= 1'b0;
      p2_a_q <= '0;
      dqm_q  <= '0;
      dq_i_q <= '0;
      err_q  <= 4'b0000;
    end else begin
      bl_q   <= bl_d;
      cl3_q  <= cl3_d;
      open_q <= open_d;
      row_q  <= row_d;
      st_q   <= st_d;
      bba_q  <= bba_d;
      brow_q <= brow_d;
      bcol_q <= bcol_d;
      bcnt_q <= bcnt_d;
      p1_v_q <= p1_v_d;
      p1_a_q <= p1_a_d;
      p2_v_q <= p2_v_d;
      p2_a_q <= p2_a_d;
      dqm_q  <= dqm_d;
      dq_i_q <= dq_i_d;
      err_q  <= err_d;
    end
  end

  // storage array with byte-lane write enables, never reset
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      for (int b = 0; b < W_BE; b++) begin
        if (wr_be[b]) mem[wr_a][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign sdram_dq_i = dq_i_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_sdram_synth_model.sv
// Directed vector bench for sdram_synth_model.
// One record per clock edge; outputs checked on the following negedge.
module tb_sdram_synth_model;

  localparam int NOP = 7;
  localparam int ACT = 3;
  localparam int RD  = 5;
  localparam int WR  = 4;
  localparam int PRE = 2;
  localparam int REF = 1;
  localparam int MRS = 0;
  localparam int BST = 6;

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic [15:0] dq;
    logic        cke;
    logic        clr;
    logic [15:0] exp_dq;
    logic [3:0]  exp_err;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst_n_por;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_o;
  logic [15:0] sdram_dq_i;
  logic        sdram_clke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic        err_clear;
  logic [3:0]  err_flags;

  vec_t        vq[$];
  logic [3:0]  xe;
  int          n_chk;
  int          n_fail;

  sdram_synth_model dut (
    .clk_sys    (clk_sys),
    .rst_n_por  (rst_n_por),
    .sdram_ba   (sdram_ba),
    .sdram_a    (sdram_a),
    .sdram_dqm  (sdram_dqm),
    .sdram_dq_o (sdram_dq_o),
    .sdram_dq_i (sdram_dq_i),
    .sdram_clke (sdram_clke),
    .sdram_cs_n (sdram_cs_n),
    .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n),
    .sdram_we_n (sdram_we_n),
    .err_clear  (err_clear),
    .err_flags  (err_flags)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic void add(
    input int c, input int ba, input int a, input int xdq,
    input int dqm = 0, input int dq = 0,
    input int cke = 1, input int clr = 0
  );
    vec_t v;
    v.cmd     = 3'(c);
    v.ba      = 2'(ba);
    v.a       = 13'(a);
    v.exp_dq  = 16'(xdq);
    v.dqm     = 2'(dqm);
    v.dq      = 16'(dq);
    v.cke     = 1'(cke);
    v.clr     = 1'(clr);
    v.exp_err = xe;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int c, input int ba, input int a,
                       input logic cs_n);
    sdram_cs_n = cs_n;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'(c);
    sdram_ba = 2'(ba);
    sdram_a  = 13'(a);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    xe = 4'h0;
    // basic write / read, BL8 CL2
    add(NOP, 0, 0, 0);
    add(MRS, 0, 'h023, 0);
    add(ACT, 1, 5, 0);
    add(WR, 1, 0, 0, 0, 'h1000);
    for (int k = 1; k < 8; k++) add(NOP, 0, 0, 0, 0, 'h1000 + k);
    add(RD, 1, 0, 0);
    for (int k = 0; k < 8; k++) add(NOP, 0, 0, 'h1000 + k);
    add(NOP, 0, 0, 0);
    // CL3 BL4 wrapped read from col 6
    add(PRE, 0, 'h400, 0);
    add(MRS, 0, 'h032, 0);
    add(ACT, 1, 5, 0);
    add(RD, 1, 6, 0);
    add(NOP, 0, 0, 0);
    add(NOP, 0, 0, 'h1006);
    add(NOP, 0, 0, 'h1007);
    add(NOP, 0, 0, 'h1004);
    add(NOP, 0, 0, 'h1005);
    add(NOP, 0, 0, 0);
    // DQM on write and read, CL2 BL4
    add(PRE, 0, 'h400, 0);
    add(MRS, 0, 'h022, 0);
    add(ACT, 1, 5, 0);
    add(WR, 1, 0, 0, 3, 'hFFFF);
    add(NOP, 0, 0, 0, 1, 'hABCD);
    add(NOP, 0, 0, 0, 3, 'hEEEE);
    add(NOP, 0, 0, 0, 3, 'hEEEE);
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000, 2);
    add(NOP, 0, 0, 'h0001);
    add(NOP, 0, 0, 'h1002);
    add(NOP, 0, 0, 'h1003);
    add(RD, 1, 1, 0);
    add(NOP, 0, 0, 'hAB01);
    add(NOP, 0, 0, 'h1002);
    add(NOP, 0, 0, 'h1003);
    add(NOP, 0, 0, 'h1000);
    add(NOP, 0, 0, 0);
    // precharge truncation, then read to closed bank
    add(PRE, 0, 'h400, 0);
    add(MRS, 0, 'h023, 0);
    add(ACT, 1, 5, 0);
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000);
    add(NOP, 0, 0, 'hAB01);
    add(NOP, 0, 0, 'h1002);
    add(PRE, 1, 0, 'h1003);
    add(NOP, 0, 0, 0);
    xe = 4'h1;
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 0);
    // ACT on open bank, bad MRS, clear
    add(ACT, 1, 5, 0);
    xe = 4'h3;
    add(ACT, 1, 7, 0);
    add(PRE, 0, 'h400, 0);
    xe = 4'hB;
    add(MRS, 0, 'h047, 0);
    xe = 4'h0;
    add(NOP, 0, 0, 0, 0, 0, 1, 1);
    add(ACT, 1, 5, 0);
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000);
    add(NOP, 0, 0, 'hAB01);
    for (int k = 2; k < 8; k++) add(NOP, 0, 0, 'h1000 + k);
    add(NOP, 0, 0, 0);
    xe = 4'h4;
    add(REF, 0, 0, 0);
    xe = 4'h2;
    add(ACT, 1, 5, 0, 0, 0, 1, 1);
    xe = 4'h0;
    add(NOP, 0, 0, 0, 0, 0, 1, 1);
    // burst terminate and write turnaround
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000);
    add(BST, 0, 0, 'hAB01);
    add(NOP, 0, 0, 0);
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000);
    add(WR, 1, 8, 0, 0, 'h3000);
    for (int k = 1; k < 8; k++) add(NOP, 0, 0, 0, 0, 'h3000 + k);
    add(RD, 1, 8, 0);
    for (int k = 0; k < 8; k++) add(NOP, 0, 0, 'h3000 + k);
    add(NOP, 0, 0, 0);
    // clock suspend stretches the burst
    add(RD, 1, 0, 0);
    add(NOP, 0, 0, 'h1000);
    add(NOP, 0, 0, 'hAB01);
    add(NOP, 0, 0, 'h1002);
    for (int k = 0; k < 3; k++) add(NOP, 0, 0, 'h1002, 0, 0, 0);
    for (int k = 3; k < 8; k++) add(NOP, 0, 0, 'h1000 + k);
    add(NOP, 0, 0, 0);

    rst_n_por  = 1'b0;
    sdram_clke = 1'b1;
    sdram_dqm  = 2'b00;
    sdram_dq_o = 16'h0;
    err_clear  = 1'b0;
    drive(NOP, 0, 0, 1'b0);
    repeat (3) @(negedge clk_sys);
    rst_n_por = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].cmd, vq[i].ba, vq[i].a, 1'b0);
      sdram_dqm  = vq[i].dqm;
      sdram_dq_o = vq[i].dq;
      sdram_clke = vq[i].cke;
      err_clear  = vq[i].clr;
      @(negedge clk_sys);
      chk($sformatf("v%0d dq", i), sdram_dq_i, vq[i].exp_dq);
      chk($sformatf("v%0d err", i), 16'(err_flags),
          16'(vq[i].exp_err));
    end

    // reset in the middle of a burst
    sdram_clke = 1'b1;
    sdram_dqm  = 2'b00;
    err_clear  = 1'b0;
    drive(RD, 1, 0, 1'b0);
    @(negedge clk_sys);
    drive(NOP, 0, 0, 1'b0);
    @(negedge clk_sys);
    chk("rst pre w0", sdram_dq_i, 16'h1000);
    @(negedge clk_sys);
    chk("rst pre w1", sdram_dq_i, 16'hAB01);
    rst_n_por = 1'b0;
    #1;
    chk("rst dq", sdram_dq_i, 16'h0000);
    chk("rst err", 16'(err_flags), 16'h0000);
    @(negedge clk_sys);
    rst_n_por = 1'b1;
    drive(RD, 1, 0, 1'b1);
    @(negedge clk_sys);
    chk("deselect err", 16'(err_flags), 16'h0000);
    chk("after rst dq", sdram_dq_i, 16'h0000);
    drive(RD, 1, 0, 1'b0);
    @(negedge clk_sys);
    chk("closed after rst", 16'(err_flags), 16'h0001);
    drive(NOP, 0, 0, 1'b0);
    @(negedge clk_sys);
    chk("no burst after rst", sdram_dq_i, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
